// File: rtl/pin_edge_meter.sv
// pin_edge_meter: synchronises one pin, counts its rising edges over a
// fixed gate window and offers the saturated count on a valid/ready port.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           tile enable; 0 freezes FSM and counters (not the synchroniser)
//   sig_in        asynchronous pin being measured
//   start         request a measurement (sampled only when idle)
//   busy          high while a measurement window is open
//   result        latched edge count, saturating at 2^CNT_W-1
//   overflow      count saturated during the last window
//   result_valid  result available; held until result_ready
//   result_ready  consumer accepts the result
module pin_edge_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             overflow,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        HOLD
    } state_t;

    state_t state, state_nx;

    logic             sync1, sync2, prev;
    logic             rise;
    logic [CNT_W-1:0] edge_cnt, edge_nx;
    logic [GW-1:0]    gate_cnt, gate_nx;
    logic [CNT_W-1:0] result_nx;
    logic             ovf_nx;

    // Synchroniser and edge history run regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    always_comb begin
        state_nx  = state;
        edge_nx   = edge_cnt;
        gate_nx   = gate_cnt;
        result_nx = result;
        ovf_nx    = overflow;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = MEASURE;
                    edge_nx  = '0;
                    gate_nx  = GATE_LAST;
                    ovf_nx   = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (edge_cnt == CNT_MAX) begin
                        ovf_nx = 1'b1;
                    end else begin
                        edge_nx = edge_cnt + 1'b1;
                    end
                end
                // Last sample of the window: latch the count including
                // this cycle's edge (edge_nx already saturates).
                if (gate_cnt == '0) begin
                    state_nx  = HOLD;
                    result_nx = edge_nx;
                end else begin
                    gate_nx = gate_cnt - 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            edge_cnt <= '0;
            gate_cnt <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (ena) begin
            state    <= state_nx;
            edge_cnt <= edge_nx;
            gate_cnt <= gate_nx;
            result   <= result_nx;
            overflow <= ovf_nx;
        end
    end

    assign busy         = (state == MEASURE);
    assign result_valid = (state == HOLD);

endmodule

// File: tb/tb_pin_edge_meter.sv
// tb_pin_edge_meter: random and directed stimulus for two pin_edge_meter
// instances (16-cycle/8-bit and 64-cycle/4-bit) against a history model.
module tb_pin_edge_meter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena, sig_in;
    logic       start_a, start_b, ready_a, ready_b;
    logic       busy_a, busy_b, ovf_a, ovf_b, val_a, val_b;
    logic [7:0] res_a;
    logic [3:0] res_b;

    pin_edge_meter #(.GATE_CYCLES(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in),
        .start(start_a), .busy(busy_a), .result(res_a),
        .overflow(ovf_a), .result_valid(val_a), .result_ready(ready_a)
    );

    pin_edge_meter #(.GATE_CYCLES(64), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in),
        .start(start_b), .busy(busy_b), .result(res_b),
        .overflow(ovf_b), .result_valid(val_b), .result_ready(ready_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pin and enable history as seen at each rising edge (index = edge no.)
    int cyc = 0;
    int base = 0;
    bit sig_hist [0:8191];
    bit ena_hist [0:8191];

    always @(posedge clk) begin
        sig_hist[cyc+1] <= sig_in;
        ena_hist[cyc+1] <= ena;
        cyc <= cyc + 1;
    end

    int mode = 4;
    int pulse_at = -10;

    always @(negedge clk) begin
        case (mode)
            0: sig_in <= 1'($urandom % 2);
            1: sig_in <= ((cyc / 2) % 2) == 1;
            2: sig_in <= 1'b1;
            3: sig_in <= ~sig_in;
            5: sig_in <= (cyc == pulse_at);
            default: sig_in <= 1'b0;
        endcase
    end

    function automatic bit samp(input int k);
        if (k <= base || k < 1) return 1'b0;
        return sig_hist[k];
    endfunction

    // A pin rise counted at edge k: high sampled at k-2, low at k-3.
    function automatic bit rise_at(input int k);
        return samp(k - 2) && !samp(k - 3);
    endfunction

    task automatic model(input int s, input int gate, input int w,
                         output int end_k, output int res, output int ovf);
        int n = 0;
        int c = 0;
        int maxv = (1 << w) - 1;
        end_k = -1;
        for (int k = s + 1; k <= cyc; k++) begin
            if (ena_hist[k]) begin
                n++;
                if (rise_at(k)) c++;
                if (n == gate) begin
                    end_k = k;
                    break;
                end
            end
        end
        res = (c > maxv) ? maxv : c;
        ovf = (c > maxv) ? 1 : 0;
    endtask

    task automatic run(input bit b, input int st_at, input int st_len,
                       input int hold, input int e_lat,
                       input int e_res, input int e_ovf);
        int s, i, lat, m_end, m_res, m_ovf, r, gate, w;
        gate = b ? 64 : 16;
        w = b ? 4 : 8;
        check("idle_busy", int'(b ? busy_b : busy_a), 0);
        ena = 1'b1;
        if (b) start_b = 1'b1;
        else start_a = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy_up", int'(b ? busy_b : busy_a), 1);
        check("ovf_clr", int'(b ? ovf_b : ovf_a), 0);
        i = 0;
        while (!(b ? val_b : val_a) && i < 300) begin
            if (i == st_at) ena = 1'b0;
            if (i == st_at + st_len) ena = 1'b1;
            @(negedge clk);
            i++;
        end
        ena = 1'b1;
        if (!(b ? val_b : val_a)) begin
            check("timeout", 0, 1);
            return;
        end
        lat = cyc - s;
        r = b ? int'(res_b) : int'(res_a);
        model(s, gate, w, m_end, m_res, m_ovf);
        check("latency", lat, m_end - s);
        check("result", r, m_res);
        check("overflow", int'(b ? ovf_b : ovf_a), m_ovf);
        check("busy_dn", int'(b ? busy_b : busy_a), 0);
        if (e_lat >= 0) check("latency_c", lat, e_lat);
        if (e_res >= 0) check("result_c", r, e_res);
        if (e_ovf >= 0) check("overflow_c", int'(b ? ovf_b : ovf_a), e_ovf);
        for (int j = 0; j < hold; j++) begin
            if (b) start_b = (j == 2);
            else start_a = (j == 2);
            @(negedge clk);
            check("hold_valid", int'(b ? val_b : val_a), 1);
            check("hold_res", b ? int'(res_b) : int'(res_a), r);
            check("hold_busy", int'(b ? busy_b : busy_a), 0);
        end
        // Handshake with start held high: start must not be taken.
        if (b) begin
            ready_b = 1'b1;
            start_b = 1'b1;
        end else begin
            ready_a = 1'b1;
            start_a = 1'b1;
        end
        @(negedge clk);
        check("hs_valid", int'(b ? val_b : val_a), 0);
        check("hs_busy", int'(b ? busy_b : busy_a), 0);
        ready_a = 1'b0;
        ready_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("post_busy", int'(b ? busy_b : busy_a), 0);
        check("post_res", b ? int'(res_b) : int'(res_a), r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_val", int'(val_a), 0);
        check("rst_ovf", int'(ovf_a), 0);
        check("rst_res", int'(res_a), 0);
        rst_n = 1'b1;
        base = cyc;
        repeat (3) @(negedge clk);

        mode = 1;
        repeat (4) @(negedge clk);
        run(0, -1, 0, 3, 16, 4, 0);

        mode = 2;
        repeat (5) @(negedge clk);
        run(0, -1, 0, 2, 16, 0, 0);

        mode = 4;
        repeat (5) @(negedge clk);
        pulse_at = cyc + 5;
        mode = 5;
        run(0, -1, 0, 1, 16, 1, 0);

        mode = 0;
        run(0, -1, 0, 10, 16, -1, -1);
        run(0, 4, 5, 2, 21, -1, -1);

        mode = 3;
        run(1, -1, 0, 2, 64, 15, 1);
        mode = 0;
        run(1, -1, 0, 2, 64, -1, -1);

        for (int k = 0; k < 6; k++) begin
            run(1'(k % 2), int'($urandom_range(0, 10)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                -1, -1, -1);
        end

        // Asynchronous reset in the middle of an overflowing window.
        mode = 3;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_rst_ovf", int'(ovf_b), 1);
        check("pre_rst_busy", int'(busy_b), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy_b), 0);
        check("mid_rst_val", int'(val_b), 0);
        check("mid_rst_ovf", int'(ovf_b), 0);
        check("mid_rst_res", int'(res_b), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        @(negedge clk);
        check("rel_busy", int'(busy_b), 0);
        check("rel_val", int'(val_b), 0);
        mode = 0;
        run(0, -1, 0, 1, 16, -1, -1);
        run(1, 7, 3, 1, 67, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
